// File: rtl/uart_receive_if.sv
// rtl/uart_receive_if.sv - received-byte handshake bundle for uart_receive
// Error pulses exist only when UART_RECEIVE_ERROR_EN is defined.
interface uart_receive_if;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       i_data_ready;
`ifdef UART_RECEIVE_ERROR_EN
    logic       o_frame_error;
    logic       o_overrun;

    modport master (output o_data, output o_data_valid, input i_data_ready,
                    output o_frame_error, output o_overrun);
    modport slave  (input o_data, input o_data_valid, output i_data_ready,
                    input o_frame_error, input o_overrun);
`else
    modport master (output o_data, output o_data_valid, input i_data_ready);
    modport slave  (input o_data, input o_data_valid, output i_data_ready);
`endif
endinterface

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - UART 8N1 receiver with single-entry valid/ready output buffer
// Optional frame-error/overrun pulses under UART_RECEIVE_ERROR_EN.
module uart_receive #(
    parameter int CLOCK_FREQUENCY = 125_000_000,
    parameter int BAUD_RATE       = 115_200
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rx,
    uart_receive_if.master    rx_if
);
    localparam int N_CLOCKS = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int N_WIDTH  = $clog2(N_CLOCKS);
    localparam logic [N_WIDTH-1:0] LAST_COUNT = N_WIDTH'(N_CLOCKS - 1);
    localparam logic [N_WIDTH-1:0] MID_COUNT  = N_WIDTH'(N_CLOCKS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t             state_q, state_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;
    logic [N_WIDTH-1:0] count_q, count_d;
    logic [3:0]         bit_count_q, bit_count_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               deliver;
`ifdef UART_RECEIVE_ERROR_EN
    logic               frame_error_q, frame_error_d;
    logic               overrun_q, overrun_d;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            count_q       <= '0;
            bit_count_q   <= '0;
            shift_q       <= 8'h00;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
`ifdef UART_RECEIVE_ERROR_EN
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            count_q       <= count_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
`ifdef UART_RECEIVE_ERROR_EN
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_meta_d   = i_rx;
        rx_s_d      = rx_meta_q;
        count_d     = count_q + 1'b1;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        deliver     = 1'b0;
`ifdef UART_RECEIVE_ERROR_EN
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check at mid start bit so short low glitches are ignored.
                if (count_q == MID_COUNT) begin
                    count_d     = '0;
                    bit_count_d = '0;
                    state_d     = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (count_q == LAST_COUNT) begin
                    count_d     = '0;
                    shift_d     = {rx_s_q, shift_q[7:1]};
                    bit_count_d = bit_count_q + 4'd1;
                    if (bit_count_q == 4'd7) begin
                        bit_count_d = '0;
                        state_d     = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                if (count_q == LAST_COUNT) begin
                    count_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
`ifdef UART_RECEIVE_ERROR_EN
                        frame_error_d = 1'b1;
`endif
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                count_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase

        // A new byte may replace one being consumed on the same edge.
        if (deliver) begin
            if (!valid_q || rx_if.i_data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
`ifdef UART_RECEIVE_ERROR_EN
                overrun_d = 1'b1;
`endif
            end
        end else if (valid_q && rx_if.i_data_ready) begin
            valid_d = 1'b0;
        end
    end

    assign rx_if.o_data       = data_q;
    assign rx_if.o_data_valid = valid_q;
`ifdef UART_RECEIVE_ERROR_EN
    assign rx_if.o_frame_error = frame_error_q;
    assign rx_if.o_overrun     = overrun_q;
`endif
endmodule
